// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic inter-stage pipeline register with a valid/ready handshake and a
//   2-entry skid buffer. The payload is one packed WIDTH-bit vector that the
//   caller packs and unpacks. It accepts one entry per cycle while downstream
//   keeps up. in_ready is a plain register with no combinational path from
//   in_valid or out_ready. A flush input discards everything held, and a
//   saturating counter records cycles where output is stalled.
//
// Ports
//   clk        in   1      clock, all state changes on the rising edge
//   reset      in   1      synchronous, active-high; has priority over flush
//   flush      in   1      discard all held entries and any same-cycle input
//   in_valid   in   1      upstream offers in_data
//   in_ready   out  1      stage can accept (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream accepts out_data
//   out_data   out  WIDTH  head entry (main register)
//   occupancy  out  2      entries held: 0, 1 or 2
//   stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned      WIDTH          = 152,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned      CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // EMPTY: nothing held. BUSY: head in main. FULL: head in main, next in skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Selects what the main (head) register loads this cycle.
    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,
        SRC_IN    = 2'd1,
        SRC_SKID  = 2'd2,
        SRC_RESET = 2'd3
    } main_src_t;

    state_t           r_state;
    state_t           w_state_nxt;
    main_src_t        w_main_src;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_stalled;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occupancy;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in_acc  = in_valid & r_in_ready;
    assign w_out_acc = r_out_valid & out_ready;
    assign w_stalled = r_out_valid & ~out_ready;

    // Next-state and data-steering decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would infer a latch.
        w_state_nxt  = r_state;
        w_main_src   = SRC_HOLD;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        case (r_state)
            EMPTY: begin
                if (w_in_acc) begin
                    w_state_nxt = BUSY;
                    w_main_src  = SRC_IN;
                end
            end
            BUSY: begin
                if (w_in_acc && w_out_acc) begin
                    w_main_src = SRC_IN;
                end else if (w_in_acc) begin
                    // Head is still waiting downstream, so park the new entry.
                    w_state_nxt = FULL;
                    w_skid_load = 1'b1;
                end else if (w_out_acc) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain case exists.
                if (w_out_acc) begin
                    w_state_nxt = BUSY;
                    w_main_src  = SRC_SKID;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase

        // Flush overrides everything: same-cycle input is dropped and a
        // same-cycle output handshake simply counts as consumed.
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_skid_load  = 1'b0;
            w_main_src   = CLEAR_ON_FLUSH ? SRC_RESET : SRC_HOLD;
            w_skid_clear = CLEAR_ON_FLUSH;
        end
    end

    // Control FSM. The handshake outputs are decoded from the next state and
    // registered, so in_ready never depends combinationally on the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            case (w_state_nxt)
                BUSY:    r_occupancy <= 2'd1;
                FULL:    r_occupancy <= 2'd2;
                default: r_occupancy <= 2'd0;
            endcase
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data registers are reset on purpose. out_data is
            // defined as RESET_VAL after reset, so it is observable state and
            // not just a don't-care storage array.
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            case (w_main_src)
                SRC_IN:    r_main <= in_data;
                SRC_SKID:  r_main <= r_skid;
                SRC_RESET: r_main <= RESET_VAL;
                default:   r_main <= r_main;
            endcase
            if (w_skid_clear) begin
                r_skid <= RESET_VAL;
            end else if (w_skid_load) begin
                r_skid <= in_data;
            end
        end
    end

    // Stall counter: saturates at all-ones. Only reset clears it; flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occupancy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed bench for pipe_stage_skid. A queue holds the entries the stage
//   should contain. An accepted input is pushed, an output handshake pops the
//   head, and a flush or reset empties the queue. The DUT's in_ready,
//   out_valid, occupancy, out_data and stall_cnt are compared with values
//   derived from this queue and from a bench-side saturating stall count.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int unsigned      W     = 16;
    localparam int unsigned      CW    = 4;
    localparam logic [W-1:0]     RVAL  = 16'hDEAD;
    localparam logic [CW-1:0]    SAT   = 4'hF;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    pipe_stage_skid #(
        .WIDTH          (W),
        .RESET_VAL      (RVAL),
        .CLEAR_ON_FLUSH (1'b1),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_total = 0;
    int unsigned   n_pass  = 0;
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare the registered outputs against the scoreboard state.
    task automatic check_state(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < 2));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(exp_q.size()));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        if (exp_q.size() != 0) begin
            check({tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
        end
    endtask

    // One clock cycle. Called #1 after a rising edge: check outputs, drive
    // inputs, predict the handshake, advance, and update the scoreboard.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        logic acc_in;
        logic acc_out;
        check_state(tag);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc_in  = v && (exp_q.size() < 2);
        acc_out = (exp_q.size() != 0) && ordy;
        if ((exp_q.size() != 0) && !ordy && (m_stall != SAT)) begin
            m_stall = m_stall + 1'b1;
        end
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (acc_out) void'(exp_q.pop_front());
            if (acc_in)  exp_q.push_back(d);
        end
    endtask

    // Synchronous reset with hostile inputs held during reset.
    task automatic apply_reset(input int cycles);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h5A5A;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        m_stall = '0;
        check("rst.out_valid", 32'(out_valid), 32'(0));
        check("rst.in_ready",  32'(in_ready),  32'(1));
        check("rst.occupancy", 32'(occupancy), 32'(0));
        check("rst.out_data",  32'(out_data),  32'(RVAL));
        check("rst.stall_cnt", 32'(stall_cnt), 32'(0));
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_stall   = '0;
        @(posedge clk);
        #1;

        // 1: reset with in_valid=1, out_ready=0 for two cycles.
        apply_reset(2);

        // 2: streaming 0x01..0x10 with out_ready=1, one entry per cycle.
        for (int i = 1; i <= 16; i++) begin
            step("stream", 1'b1, W'(i), 1'b1, 1'b0);
            check("stream.occ1", 32'(occupancy), 32'(1));
        end
        step("stream_drain", 1'b0, '0, 1'b1, 1'b0);
        step("stream_idle",  1'b0, '0, 1'b1, 1'b0);

        // 3: back-pressure. A and B fill the stage, C waits upstream.
        step("bp_a",    1'b1, 16'h000A, 1'b0, 1'b0);
        step("bp_b",    1'b1, 16'h000B, 1'b0, 1'b0);
        check("bp.full_occ", 32'(occupancy), 32'(2));
        step("bp_c0",   1'b1, 16'h000C, 1'b0, 1'b0);
        step("bp_c1",   1'b1, 16'h000C, 1'b1, 1'b0);
        step("bp_c2",   1'b1, 16'h000C, 1'b1, 1'b0);
        step("bp_out",  1'b0, '0,       1'b1, 1'b0);
        step("bp_idle", 1'b0, '0,       1'b1, 1'b0);
        step("bp_idle", 1'b0, '0,       1'b1, 1'b0);

        // 4: flush while FULL, with D offered in the same cycle.
        step("fl_a", 1'b1, 16'h0011, 1'b0, 1'b0);
        step("fl_b", 1'b1, 16'h0022, 1'b0, 1'b0);
        step("fl_d", 1'b1, 16'h000D, 1'b0, 1'b1);
        check("flush.out_data", 32'(out_data), 32'(RVAL));
        for (int i = 0; i < 3; i++) begin
            step("fl_after", 1'b0, 16'h000D, 1'b1, 1'b0);
        end

        // 5: stall counter saturation, then a flush leaves it at the maximum.
        apply_reset(1);
        step("st_load", 1'b1, 16'h0055, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("stall", 1'b0, '0, 1'b0, 1'b0);
        end
        check("stall.sat", 32'(stall_cnt), 32'(15));
        step("st_flush", 1'b0, '0, 1'b0, 1'b1);
        step("st_after", 1'b0, '0, 1'b1, 1'b0);
        check("stall.after_flush", 32'(stall_cnt), 32'(15));

        // 6: reset while FULL with out_ready=1; nothing is emitted afterwards.
        step("r6_a", 1'b1, 16'h0066, 1'b0, 1'b0);
        step("r6_b", 1'b1, 16'h0077, 1'b0, 1'b0);
        check("r6.full_occ", 32'(occupancy), 32'(2));
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0088;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_stall = '0;
        check("r6.occupancy", 32'(occupancy), 32'(0));
        check("r6.out_valid", 32'(out_valid), 32'(0));
        for (int i = 0; i < 3; i++) begin
            step("r6_after", 1'b0, '0, 1'b1, 1'b0);
        end
        check_state("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
